hdr_writer: RTL
===============

Name: hdr_writer

Overview:
- Write-back end of the header path: when `proc` signals `ready_o`, this block captures the processed header byte array.
- It serialises the captured bytes into big-endian 32-bit word writes on a BRAM/SRAM write port at a configurable word base address.
- It is the counterpart of the BRAM-to-`pkt_hdr_i` load path. It closes the loop so processed headers are returned to packet memory.
- It sits between `proc` and the packet-memory write port, for example BRAM port B.

Parameters:
- HDR_LEN, `HDR_MAX_LEN (64), number of bytes in the header array.
- ADDR_W, 10, word-address width of the memory port.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start_i  input  1  one-cycle pulse, driven from proc `ready_o`
- pkt_hdr_i  input  HDR_LEN x `BYTE_BUS  processed header; byte 0 is the first on wire
- hdr_len_i  input  7  valid byte count; sampled with start_i
- base_addr_i  input  ADDR_W  word address of the first write; sampled with start_i
- wr_ready_i  input  1  memory accepts the current write this cycle
- mem_ce_o  output  1  write-port enable
- mem_we_o  output  1  write enable
- mem_addr_o  output  ADDR_W  word address
- mem_sel_o  output  4  byte enables; bit3 = [31:24]
- mem_data_o  output  `DATA_BUS  write data
- busy_o  output  1  capture/write in progress
- done_o  output  1  one-cycle pulse after the last accepted write
- err_o  output  1  one-cycle pulse when start_i arrives while busy

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 immediately. FSM goes to IDLE.
  - Header register is cleared, including mid-transfer. No done_o is produced for an aborted transfer.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - On start_i, capture pkt_hdr_i, the length and base_addr_i into registers.
  - Length is clamped to HDR_LEN (hdr_len_i > HDR_LEN is treated as HDR_LEN).
  - Word count N = ceil(len/4); word index k = 0.
  - If N = 0, go to DONE; otherwise go to WRITE.
- WRITE:
  - Drive mem_ce_o = mem_we_o = 1 and mem_addr_o = (base + k) mod 2^ADDR_W; the address wraps silently.
  - mem_data_o = {byte 4k, 4k+1, 4k+2, 4k+3}, big-endian.
  - A transfer occurs when wr_ready_i = 1. On transfer, k increments; if k = N-1, go to DONE.
  - With wr_ready_i = 0, address, data and sel hold stable and the FSM stays.
- DONE: done_o = 1 for one cycle; mem_ce_o = mem_we_o = 0; return to IDLE.
- Byte enables:
  - mem_sel_o = 4'b1111 for all words except the last.
  - On the last word, with rem = len mod 4: rem 0 gives 1111, rem 1 gives 1000, rem 2 gives 1100, rem 3 gives 1110.
  - Disabled byte lanes carry 8'h00.
- Latency (wr_ready_i held high):
  - start_i at cycle T; first write at T+1; word k at T+1+k.
  - done_o at T+N+1.
  - busy_o is high from T+1 through the done_o cycle.
- Start while busy (WRITE or DONE):
  - start_i is ignored and err_o pulses for that cycle.
  - The in-flight transfer is unaffected.
  - start_i in the same cycle as done_o also counts as busy.
- Registers are updated only by start_i in IDLE; changes on pkt_hdr_i after capture have no effect.

Decomposition:
- Use the existing def.svh macros: `BYTE_BUS, `DATA_BUS, `HDR_MAX_LEN, `TRUE/`FALSE.
- Add to the shared package:
  - FSM state typedef hdr_wr_state_t (IDLE/WRITE/DONE).
  - Constant HDR_WORD_BYTES = 4.
- One combinational sub-module, hdr_word_pack:
  - Inputs: header bytes, word index k, length.
  - Outputs: packed masked data word and sel.

Test Plan:
- Full header:
  - Stimulus: the 60-byte test header (c8 58 c0 b5 fe 1e 90 03 ...), len 60, base 0x21c, wr_ready_i = 1.
  - Response: 15 writes at 0x21c..0x22a, data c858c0b5, fe1e9003, 25b97f06, 08004500, ..., last 00000000; all sel 1111; done_o at T+16.
- Partial word:
  - Stimulus: same header, len 14, base 0x000.
  - Response: 4 writes; last at 0x003, data 08000000, sel 1100; done_o at T+5.
- Backpressure and wrap:
  - Stimulus: len 8, base 0x3ff; wr_ready_i low for 3 cycles on word 0.
  - Response: word 0 held stable at 0x3ff for 4 cycles; word 1 at 0x000; done_o at T+6.
- Zero length and clamp:
  - Stimulus: len 0, then len 100 in a separate transfer.
  - Response: len 0 gives no writes and done_o at T+1. Len 100 gives 16 writes, all sel 1111.
- Start while busy:
  - Stimulus: second start_i 2 cycles into a 60-byte transfer.
  - Response: err_o pulses once; the 15 original writes are unchanged; exactly one done_o.
- Reset mid-transfer:
  - Stimulus: assert rst asynchronously after word 5.
  - Response: mem_ce_o, mem_we_o and busy_o drop immediately; no done_o; the next start_i restarts from word 0 at the new base.

Source files
------------

// File: rtl/hdr_writer_pkg.sv
// Shared types and constants for the header write-back path, plus the bus-width
// macros used by every file of this block.
`ifndef HDR_WRITER_DEFS
`define HDR_WRITER_DEFS
`define BYTE_BUS 7:0
`define DATA_BUS 31:0
`define HDR_MAX_LEN 64
`define TRUE 1'b1
`define FALSE 1'b0
`endif

package hdr_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } hdr_wr_state_t;

  localparam int HDR_WORD_BYTES = 4;

  // Number of 32-bit words needed to hold len bytes (ceil(len/4)).
  function automatic logic [6:0] word_count(input logic [6:0] len);
    logic [7:0] sum;
    sum = {1'b0, len} + 8'd3;
    return 7'(sum[7:2]);
  endfunction

endpackage

// File: rtl/hdr_word_pack.sv
// Packs header bytes 4k..4k+3 into one big-endian word; lanes at or beyond the
// valid length are disabled and forced to zero.
module hdr_word_pack
  import hdr_writer_pkg::*;
#(
  parameter int HDR_LEN = `HDR_MAX_LEN
) (
  input  logic [HDR_LEN-1:0][`BYTE_BUS] hdr,
  input  logic [6:0]                    word_idx,
  input  logic [6:0]                    len,
  output logic [`DATA_BUS]              data,
  output logic [3:0]                    sel
);

  localparam int IDX_W = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;

  logic [8:0] byte_idx_s;

  // Lane j carries byte 4k+j in bits [31-8j -: 8]; sel bit 3 is the first byte.
  always_comb begin
    data       = 32'h0000_0000;
    sel        = 4'b0000;
    byte_idx_s = 9'd0;
    for (int j = 0; j < HDR_WORD_BYTES; j++) begin
      byte_idx_s = {word_idx, 2'b00} + 9'(j);
      if (byte_idx_s < {2'b00, len}) begin
        data[31-8*j -: 8] = hdr[byte_idx_s[IDX_W-1:0]];
        sel[3-j]          = 1'b1;
      end else begin
        data[31-8*j -: 8] = 8'h00;
        sel[3-j]          = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hdr_writer.sv
// Captures a processed header on start_i and writes it back to packet memory
// as consecutive big-endian 32-bit words starting at a word base address.
module hdr_writer
  import hdr_writer_pkg::*;
#(
  parameter int HDR_LEN = `HDR_MAX_LEN,
  parameter int ADDR_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [HDR_LEN-1:0][`BYTE_BUS] pkt_hdr_i,
  input  logic [6:0]                    hdr_len_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic                          wr_ready_i,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [3:0]                    mem_sel_o,
  output logic [`DATA_BUS]              mem_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam logic [6:0] HDR_LEN_C = 7'(HDR_LEN);

  hdr_wr_state_t                 state_r;
  logic [HDR_LEN-1:0][`BYTE_BUS] hdr_r;
  logic [HDR_LEN-1:0][`BYTE_BUS] pack_hdr_s;
  logic [6:0]                    len_r;
  logic [6:0]                    nwords_r;
  logic [6:0]                    k_r;
  logic [ADDR_W-1:0]             base_r;
  logic [6:0]                    len_clamp_s;
  logic [6:0]                    nwords_s;
  logic [6:0]                    pack_len_s;
  logic [6:0]                    k_next_s;
  logic [`DATA_BUS]              pack_data_s;
  logic [3:0]                    pack_sel_s;
  logic                          last_s;

  // Clamp the requested length to the header array and derive the word count.
  always_comb begin
    len_clamp_s = (hdr_len_i > HDR_LEN_C) ? HDR_LEN_C : hdr_len_i;
    nwords_s    = word_count(len_clamp_s);
  end

  // The packer looks one word ahead so the output registers load the word that
  // is presented in the next cycle; in IDLE that is word 0 of the live input.
  always_comb begin
    pack_hdr_s = hdr_r;
    pack_len_s = len_r;
    k_next_s   = k_r + 7'd1;
    if (state_r == IDLE) begin
      pack_hdr_s = pkt_hdr_i;
      pack_len_s = len_clamp_s;
      k_next_s   = 7'd0;
    end else begin
      pack_hdr_s = hdr_r;
      pack_len_s = len_r;
      k_next_s   = k_r + 7'd1;
    end
  end

  hdr_word_pack #(
    .HDR_LEN (HDR_LEN)
  ) u_pack (
    .hdr      (pack_hdr_s),
    .word_idx (k_next_s),
    .len      (pack_len_s),
    .data     (pack_data_s),
    .sel      (pack_sel_s)
  );

  assign last_s = (k_r == nwords_r - 7'd1);
  // A start that lands outside IDLE is flagged in the same cycle and dropped.
  assign err_o  = start_i && (state_r != IDLE);

  // Write-back FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hdr_r      <= '0;
      len_r      <= 7'd0;
      nwords_r   <= 7'd0;
      k_r        <= 7'd0;
      base_r     <= '0;
      mem_ce_o   <= `FALSE;
      mem_we_o   <= `FALSE;
      mem_addr_o <= '0;
      mem_sel_o  <= 4'b0000;
      mem_data_o <= 32'h0000_0000;
      busy_o     <= `FALSE;
      done_o     <= `FALSE;
    end else begin
      done_o <= `FALSE;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            hdr_r    <= pkt_hdr_i;
            len_r    <= len_clamp_s;
            nwords_r <= nwords_s;
            base_r   <= base_addr_i;
            k_r      <= 7'd0;
            busy_o   <= `TRUE;
            if (nwords_s == 7'd0) begin
              state_r <= DONE;
              done_o  <= `TRUE;
            end else begin
              state_r    <= WRITE;
              mem_ce_o   <= `TRUE;
              mem_we_o   <= `TRUE;
              mem_addr_o <= base_addr_i;
              mem_data_o <= pack_data_s;
              mem_sel_o  <= pack_sel_s;
            end
          end else begin
            busy_o <= `FALSE;
          end
        end
        WRITE: begin
          if (wr_ready_i) begin
            if (last_s) begin
              state_r    <= DONE;
              done_o     <= `TRUE;
              mem_ce_o   <= `FALSE;
              mem_we_o   <= `FALSE;
              mem_addr_o <= '0;
              mem_data_o <= 32'h0000_0000;
              mem_sel_o  <= 4'b0000;
            end else begin
              k_r        <= k_next_s;
              mem_addr_o <= base_r + ADDR_W'(k_next_s);
              mem_data_o <= pack_data_s;
              mem_sel_o  <= pack_sel_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_o  <= `FALSE;
        end
        default: begin
          state_r  <= IDLE;
          mem_ce_o <= `FALSE;
          mem_we_o <= `FALSE;
          busy_o   <= `FALSE;
        end
      endcase
    end
  end

endmodule
